// File: rtl/matriz_pkg.sv
// Shared constants, FSM state type and slot-sequencing helpers for the LED matrix scan controller.
package matriz_pkg;

    localparam int unsigned NUM_LINHAS  = 7;
    localparam int unsigned LARGURA_COL = 5;

    localparam logic [2:0] COD_DISPLAY  = 3'b000;
    localparam logic [2:0] COD_PRIMEIRA = 3'b001;
    localparam logic [2:0] COD_ULTIMA   = 3'b111;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBlank = 2'd1,
        StAceso = 2'd2
    } estado_t;

    // Row codes run 001..111, optionally followed by the display slot 000.
    function automatic logic [2:0] proximo_codigo(input logic [2:0] cod, input logic com_display);
        logic [2:0] prox;
        if (cod == COD_ULTIMA) begin
            prox = com_display ? COD_DISPLAY : COD_PRIMEIRA;
        end else if (cod == COD_DISPLAY) begin
            prox = COD_PRIMEIRA;
        end else begin
            prox = cod + 3'd1;
        end
        return prox;
    endfunction

    function automatic logic ultimo_slot(input logic [2:0] cod, input logic com_display);
        return com_display ? (cod == COD_DISPLAY) : (cod == COD_ULTIMA);
    endfunction

endpackage

// File: rtl/divisor_tick.sv
// Scan prescaler: one-clock tick every DIV clocks while enabled, held cleared otherwise.
module divisor_tick #(
    parameter int unsigned DIV = 50000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic habilita,
    output logic tick
);

    localparam logic [15:0] DIV_FIM = 16'(DIV - 1);

    logic [15:0] cont_q, cont_d;

    assign tick = habilita && (cont_q == DIV_FIM);

    always_comb begin
        cont_d = cont_q + 16'd1;
        if (!habilita || tick) begin
            cont_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cont_q <= '0;
        end else begin
            cont_q <= cont_d;
        end
    end

endmodule

// File: rtl/controlador_varredura.sv
// Row-scan controller for a 7x5 LED matrix with double-buffered column patterns and an
// optional 7-segment display slot per frame.
module controlador_varredura
    import matriz_pkg::*;
#(
    parameter int unsigned DIV         = 50000,
    parameter int unsigned BLANK_TICKS = 1,
    parameter int unsigned ON_TICKS    = 8,
    parameter int unsigned DISP_SLOT   = 1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   habilita,
    input  logic                   wr_en,
    input  logic [2:0]             wr_addr,
    input  logic [LARGURA_COL-1:0] wr_data,
    input  logic                   troca,
    output logic [2:0]             codigo,
    output logic                   valido,
    output logic [LARGURA_COL-1:0] colunas,
    output logic                   troca_ok,
    output logic                   quadro_fim
);

    localparam logic [7:0] BLANK_FIM   = 8'(BLANK_TICKS - 1);
    localparam logic [7:0] ON_FIM      = 8'(ON_TICKS - 1);
    localparam bit         COM_DISPLAY = (DISP_SLOT != 0);

    estado_t                estado_q, estado_d;
    logic [2:0]             codigo_q, codigo_d;
    logic [7:0]             ticks_q, ticks_d;
    logic                   pend_q, pend_d;
    logic                   sel_q, sel_d;
    logic [LARGURA_COL-1:0] buf0_q [NUM_LINHAS];
    logic [LARGURA_COL-1:0] buf1_q [NUM_LINHAS];
    logic [LARGURA_COL-1:0] linha_front;
    logic                   tick;
    logic                   ativo;
    logic                   fim_slot;

    // The prescaler starts counting on the BLANK entry so every slot gets full-length phases.
    assign ativo = habilita && (estado_q != StIdle);

    divisor_tick #(
        .DIV (DIV)
    ) u_divisor (
        .clock    (clock),
        .reset_n  (reset_n),
        .habilita (ativo),
        .tick     (tick)
    );

    always_comb begin
        estado_d = estado_q;
        codigo_d = codigo_q;
        ticks_d  = ticks_q;
        fim_slot = 1'b0;
        if (!habilita) begin
            estado_d = StIdle;
            codigo_d = COD_DISPLAY;
            ticks_d  = '0;
        end else begin
            case (estado_q)
                StIdle: begin
                    estado_d = StBlank;
                    codigo_d = COD_PRIMEIRA;
                    ticks_d  = '0;
                end
                StBlank: begin
                    if (tick) begin
                        if (ticks_q == BLANK_FIM) begin
                            estado_d = StAceso;
                            ticks_d  = '0;
                        end else begin
                            ticks_d = ticks_q + 8'd1;
                        end
                    end
                end
                StAceso: begin
                    if (tick) begin
                        if (ticks_q == ON_FIM) begin
                            // Code and state change on the same edge, so the new row
                            // only ever appears while blanked.
                            estado_d = StBlank;
                            ticks_d  = '0;
                            codigo_d = proximo_codigo(codigo_q, COM_DISPLAY);
                            fim_slot = 1'b1;
                        end else begin
                            ticks_d = ticks_q + 8'd1;
                        end
                    end
                end
                default: begin
                    estado_d = StIdle;
                    codigo_d = COD_DISPLAY;
                    ticks_d  = '0;
                end
            endcase
        end
    end

    assign quadro_fim = fim_slot && ultimo_slot(codigo_q, COM_DISPLAY);
    assign troca_ok   = quadro_fim && pend_q;

    // A request arriving in the commit cycle survives the clear and waits a frame.
    assign pend_d = troca || (pend_q && !troca_ok);
    assign sel_d  = sel_q ^ troca_ok;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q <= StIdle;
            codigo_q <= COD_DISPLAY;
            ticks_q  <= '0;
            pend_q   <= 1'b0;
            sel_q    <= 1'b0;
        end else begin
            estado_q <= estado_d;
            codigo_q <= codigo_d;
            ticks_q  <= ticks_d;
            pend_q   <= pend_d;
            sel_q    <= sel_d;
        end
    end

    // Writes target the back buffer selected before any swap on the same edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_LINHAS; i++) begin
                buf0_q[i] <= '0;
                buf1_q[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < NUM_LINHAS; i++) begin
                if (wr_addr == 3'(i + 1)) begin
                    if (sel_q) begin
                        buf0_q[i] <= wr_data;
                    end else begin
                        buf1_q[i] <= wr_data;
                    end
                end
            end
        end
    end

    always_comb begin
        linha_front = '0;
        for (int i = 0; i < NUM_LINHAS; i++) begin
            if (codigo_q == 3'(i + 1)) begin
                linha_front = sel_q ? buf1_q[i] : buf0_q[i];
            end
        end
    end

    assign codigo  = codigo_q;
    assign valido  = (estado_q != StAceso);
    assign colunas = (estado_q == StAceso) ? ~linha_front : '1;

endmodule
